// File: rtl/pcie_tx_symbol_mux.sv
// Serialises one TX buffer word into framed stripe symbols (STP/SDP, 4 data bytes, END/EDB, COM/FTS substitution).
// Latency: first symbol the cycle after accept; backpressure: symbols hold while out_ready=0; PCIE_TX_IDLE_FILL_EN adds D0.0 idle fill.
module pcie_tx_symbol_mux #(
  parameter logic [7:0] K_STP = 8'hFB,
  parameter logic [7:0] K_SDP = 8'h5C,
  parameter logic [7:0] K_END = 8'hFD,
  parameter logic [7:0] K_EDB = 8'hFE,
  parameter logic [7:0] K_COM = 8'hBC,
  parameter logic [7:0] K_FTS = 8'h3C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [44:0] in_rec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_sym,
  output logic        busy
);

  typedef struct packed {
    logic            valid;
    logic [1:0]      start_byte;
    logic [1:0]      end_byte;
    logic [0:3][1:0] byte_tag;
    logic [31:0]     packet_bytes;
  } tx_buffer_record_t;

  typedef struct packed {
    logic       d_k;
    logic [7:0] striped_byte;
  } stripe_record_t;

  typedef enum logic [1:0] {IDLE, START, DATA, END} t_state;

  t_state            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  tx_buffer_record_t hold_q, hold_d;
  tx_buffer_record_t rec_in;
  stripe_record_t    sym;
  logic              init_q;
  logic              xfer, last, accept;
  logic [7:0]        data_byte;

  // Encoding 11 is reserved and treated like 00 (no framing symbol).
  function automatic logic flag_on(input logic [1:0] code);
    return (code == 2'b01) || (code == 2'b10);
  endfunction

  assign rec_in = tx_buffer_record_t'(in_rec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    data_byte = 8'h00;
    case (idx_q)
      2'd0:    data_byte = hold_q.packet_bytes[31:24];
      2'd1:    data_byte = hold_q.packet_bytes[23:16];
      2'd2:    data_byte = hold_q.packet_bytes[15:8];
      default: data_byte = hold_q.packet_bytes[7:0];
    endcase
  end

  always_comb begin
    sym       = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef PCIE_TX_IDLE_FILL_EN
        // Logical idle only once the block is out of reset and ready.
        if (init_q) begin
          out_valid = 1'b1;
          sym       = '{d_k: 1'b1, striped_byte: 8'h00};
        end
`endif
      end
      START: begin
        out_valid = 1'b1;
        sym.striped_byte = (hold_q.start_byte == 2'b01) ? K_STP : K_SDP;
      end
      DATA: begin
        out_valid = 1'b1;
        case (hold_q.byte_tag[idx_q])
          2'b01:   sym.striped_byte = K_COM;
          2'b10:   sym.striped_byte = K_FTS;
          default: sym = '{d_k: 1'b1, striped_byte: data_byte};
        endcase
      end
      END: begin
        out_valid = 1'b1;
        sym.striped_byte = (hold_q.end_byte == 2'b01) ? K_END : K_EDB;
      end
      default: ;
    endcase
  end

  assign out_sym = sym;
  assign busy    = (state_q != IDLE);

  // Idle fill never counts as a transfer, so it cannot advance the FSM.
  assign xfer     = out_valid & out_ready & (state_q != IDLE);
  assign last     = xfer & (((state_q == DATA) && (idx_q == 2'd3) && !flag_on(hold_q.end_byte))
                            || (state_q == END));
  assign in_ready = init_q & ((state_q == IDLE) | last);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (xfer) begin
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = 2'd0;
        end
        DATA: begin
          if (idx_q == 2'd3)
            state_d = flag_on(hold_q.end_byte) ? END : IDLE;
          else
            idx_d = idx_q + 2'd1;
        end
        END:     state_d = IDLE;
        default: ;
      endcase
    end
    // A new word accepted on the last-symbol edge loads directly, no IDLE bubble.
    if (accept) begin
      hold_d = rec_in;
      idx_d  = 2'd0;
      if (rec_in.valid)
        state_d = flag_on(rec_in.start_byte) ? START : DATA;
      else
        state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_pcie_tx_symbol_mux.sv
// Directed bench for pcie_tx_symbol_mux: framing, tags, back-to-back, stalls, drops, reset mid-word.
module tb_pcie_tx_symbol_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [44:0] in_rec;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_sym;
  logic        busy;

  int total = 0;
  int bad   = 0;

  pcie_tx_symbol_mux dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rec   (in_rec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sym  (out_sym),
    .busy     (busy)
  );

  always #5 clk = ~clk;

`ifdef PCIE_TX_IDLE_FILL_EN
  localparam logic IDLE_VLD = 1'b1;
  localparam logic [8:0] IDLE_SYM = 9'h100;
`else
  localparam logic IDLE_VLD = 1'b0;
  localparam logic [8:0] IDLE_SYM = 9'h000;
`endif

  function automatic logic [44:0] mk(input logic v, input logic [1:0] st, input logic [1:0] en,
                                     input logic [7:0] tags, input logic [31:0] bytes);
    return {v, st, en, tags, bytes};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single cycle; it must be accepted.
  task automatic send(input logic [44:0] rec);
    in_rec   = rec;
    in_valid = 1'b1;
    #1;
    chk("accept_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_sym(input string tag, input logic [8:0] sym, input logic rdy);
    out_ready = 1'b1;
    #1;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_sym"}, 32'(out_sym), 32'(sym));
    chk({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
    tick();
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, "_vld"},  32'(out_valid), 32'(IDLE_VLD));
    chk({tag, "_sym"},  32'(out_sym), 32'(IDLE_SYM));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"},  32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [8:0] stall_exp [6];
    logic [15:0] pat;
    int k;

    rst = 1'b1; in_valid = 1'b0; in_rec = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sym",   32'(out_sym),   32'h000);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // STP/END framed word, first symbol one cycle after accept
    send(mk(1'b1, 2'b01, 2'b01, 8'h00, 32'hDEADBEEF));
    expect_sym("a0", 9'h0FB, 1'b0);
    expect_sym("a1", 9'h1DE, 1'b0);
    expect_sym("a2", 9'h1AD, 1'b0);
    expect_sym("a3", 9'h1BE, 1'b0);
    expect_sym("a4", 9'h1EF, 1'b0);
    expect_sym("a5", 9'h0FD, 1'b1);
    expect_idle("a_end");

    // COM/FTS tags, no framing
    send(mk(1'b1, 2'b00, 2'b00, 8'b01_00_10_00, 32'h11223344));
    expect_sym("b0", 9'h0BC, 1'b0);
    expect_sym("b1", 9'h122, 1'b0);
    expect_sym("b2", 9'h03C, 1'b0);
    expect_sym("b3", 9'h144, 1'b1);
    expect_idle("b_end");

    // Back-to-back: SDP/EDB word then a plain word, in_valid held high
    in_rec = mk(1'b1, 2'b10, 2'b10, 8'h00, 32'hA1B2C3D4);
    in_valid = 1'b1;
    tick();
    in_rec = mk(1'b1, 2'b00, 2'b00, 8'h00, 32'h01020304);
    expect_sym("c0", 9'h05C, 1'b0);
    expect_sym("c1", 9'h1A1, 1'b0);
    expect_sym("c2", 9'h1B2, 1'b0);
    expect_sym("c3", 9'h1C3, 1'b0);
    expect_sym("c4", 9'h1D4, 1'b0);
    expect_sym("c5", 9'h0FE, 1'b1);
    in_valid = 1'b0;
    expect_sym("d0", 9'h101, 1'b0);
    expect_sym("d1", 9'h102, 1'b0);
    expect_sym("d2", 9'h103, 1'b0);
    expect_sym("d3", 9'h104, 1'b1);
    expect_idle("d_end");

    // Stalls during a 6-symbol word
    stall_exp = '{9'h0FB, 9'h10F, 9'h11E, 9'h12D, 9'h13C, 9'h0FE};
    send(mk(1'b1, 2'b01, 2'b10, 8'h00, 32'h0F1E2D3C));
    pat = 16'b1101_0110_0100_1101;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      out_ready = (c < 16) ? pat[c] : 1'b1;
      #1;
      chk("e_vld", 32'(out_valid), 32'd1);
      chk("e_sym", 32'(out_sym), 32'(stall_exp[k]));
      chk("e_rdy", 32'(in_ready), 32'((out_ready == 1'b1) && (k == 5)));
      tick();
      if (out_ready) k++;
    end
    chk("e_count", 32'(k), 32'd6);
    out_ready = 1'b1;
    expect_idle("e_end");

    // Dropped word (valid=0) then a normal word
    send(mk(1'b0, 2'b01, 2'b01, 8'h00, 32'h55555555));
    expect_idle("drop");
    send(mk(1'b1, 2'b00, 2'b01, 8'h00, 32'hCAFEF00D));
    expect_sym("f0", 9'h1CA, 1'b0);
    expect_sym("f1", 9'h1FE, 1'b0);
    expect_sym("f2", 9'h1F0, 1'b0);
    expect_sym("f3", 9'h10D, 1'b0);
    expect_sym("f4", 9'h0FD, 1'b1);

    // Reserved 11 framing and tags behave as 00
    send(mk(1'b1, 2'b11, 2'b11, 8'hFF, 32'h01234567));
    expect_sym("i0", 9'h101, 1'b0);
    expect_sym("i1", 9'h123, 1'b0);
    expect_sym("i2", 9'h145, 1'b0);
    expect_sym("i3", 9'h167, 1'b1);
    expect_idle("i_end");

    // Reset while byte index 2 is on the output
    send(mk(1'b1, 2'b01, 2'b01, 8'h00, 32'h12345678));
    expect_sym("g0", 9'h0FB, 1'b0);
    expect_sym("g1", 9'h112, 1'b0);
    expect_sym("g2", 9'h134, 1'b0);
    #1;
    chk("g3_sym", 32'(out_sym), 32'h156);
    rst = 1'b1;
    tick();
    chk("mid_rst_vld",  32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy),      32'd0);
    chk("mid_rst_sym",  32'(out_sym),   32'h000);
    chk("mid_rst_rdy",  32'(in_ready),  32'd0);
    rst = 1'b0;
    tick();
    send(mk(1'b1, 2'b10, 2'b00, 8'h00, 32'h9ABCDEF0));
    expect_sym("h0", 9'h05C, 1'b0);
    expect_sym("h1", 9'h19A, 1'b0);
    expect_sym("h2", 9'h1BC, 1'b0);
    expect_sym("h3", 9'h1DE, 1'b0);
    expect_sym("h4", 9'h1F0, 1'b1);
    expect_idle("h_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
